spi_peripheral: RTL
===================

Name: spi_peripheral

Overview:
SPI target (peripheral) endpoint, the counterpart of the MCU's SPI controller (sclk/pico/poci/cs). It lets an FPGA-side block, or a second rvsteel_mcu board, answer transfers from the controller. All SPI inputs are oversampled and synchronised into the system clock domain. Full-duplex, MSB-first, 8-bit frames. A one-byte transmit holding register feeds the shifter, and each received byte is reported with a single-cycle strobe.

Parameters:
CPOL, 0, idle level of sclk (0 = idle low, 1 = idle high)
CPHA, 0, 0 = sample on leading edge / change on trailing edge; 1 = change on leading edge / sample on trailing edge
SYNC_STAGES, 2, flip-flop depth of the input synchronisers for sclk, pico and cs (minimum 2)

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
sclk  input  1  SPI clock from the controller; frequency must be at most clock/8
pico  input  1  controller-to-peripheral serial data
cs  input  1  chip select, active low
poci  output  1  peripheral-to-controller serial data
rx_data  output  8  last complete received byte; held until the next byte completes
rx_valid  output  1  one-cycle pulse when rx_data updates
tx_data  input  8  byte to send in a future frame
tx_write  input  1  loads tx_data into the holding register when tx_ready=1
tx_ready  output  1  holding register empty
busy  output  1  synchronised cs is active (low)

Behaviour:
- Reset values: poci=0, rx_data=8'h00, rx_valid=0, tx_ready=1, busy=0. Reset also clears:
  - the holding register and the bit counter;
  - both shifters;
  - the synchroniser chains, to the idle values sclk=CPOL, cs=1, pico=0.
- Edge detection:
  - Edges are taken from the synchronised sclk, comparing the last synchroniser stage with one extra delay flop.
  - The leading edge is rising when CPOL=0 and falling when CPOL=1.
  - Edges are ignored while the synchronised cs is high.
- Holding register (tx_pending flag):
  - tx_write while tx_ready=1 stores tx_data, sets pending and drops tx_ready in the next cycle.
  - tx_write while tx_ready=0 is ignored; the held byte is unchanged.
- Byte load: happens at each byte start (see below).
  - If pending=1: the shifter takes the held byte, pending clears and tx_ready rises in the next cycle.
  - If pending=0: the shifter takes 8'h00.
  - If tx_write arrives in the same cycle as a byte load with pending=0, the load uses 8'h00 and the new byte stays pending for the next byte.
- Byte start:
  - the cycle in which a falling synchronised cs is detected, and
  - for back-to-back bytes, the clock edge that follows the 8th sampling edge: the trailing edge for CPHA=0, the leading edge of the next bit for CPHA=1.
- State machine: IDLE, SHIFT.
  - IDLE -> SHIFT on cs falling, with bit_count=0 and the byte load done.
  - SHIFT -> IDLE on cs rising, from any bit position.
- CPHA=0 timing:
  - poci is driven with shifter[7] in the cycle after the byte load.
  - Leading edge: pico is sampled into the receive shifter (LSB-in) and bit_count increments.
  - Trailing edge: the transmit shifter shifts left and poci takes the next bit. After bit 7 it takes the MSB of the newly loaded byte instead.
- CPHA=1 timing:
  - Leading edge: poci takes the next bit (bit 7 first). At bit_count=0 the byte load happens first.
  - Trailing edge: pico is sampled and bit_count increments.
- Byte completion:
  - On the 8th sample, rx_data is updated and rx_valid pulses for exactly one cycle, in the cycle after the synchronised edge is detected.
  - End-to-end latency from the pin edge is at most SYNC_STAGES+2 clocks.
  - bit_count wraps from 7 to 0.
  - There is no backpressure: a new byte overwrites rx_data and rx_valid pulses again.
- cs deasserted mid-byte:
  - The partial received bits are discarded; there is no rx_valid and rx_data is unchanged.
  - bit_count is cleared.
  - The byte already loaded is consumed, not retransmitted.
  - poci returns to 0 in the cycle after cs rise is detected.
  - A pending byte stays pending.
- cs inactive: poci is held at 0. Tristating is the board top's job.
- Reset mid-frame: everything returns to reset values immediately. The frame is lost, and any new frame requires a fresh cs falling edge.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), clock/8 sclk:
  - Stimulus: tx_write 8'h3C before cs falls; controller sends 8'hA5.
  - Required: poci bits read back 8'h3C; rx_data=8'hA5 with exactly one rx_valid pulse; tx_ready=0 after the write and 1 after the load.
- Two back-to-back bytes in mode 0 without raising cs:
  - Stimulus: controller sends 8'h12 then 8'h34; tx_write 8'hC3 once tx_ready returns after the first load.
  - Required: controller reads 8'hC3 in the second byte; two rx_valid pulses carrying 8'h12 then 8'h34.
- No byte pending:
  - Stimulus: controller sends 8'hFF.
  - Required: poci reads 8'h00; rx_data=8'hFF.
- Abort:
  - Stimulus: cs rises after 5 sclk cycles.
  - Required: no rx_valid; rx_data keeps its old value; the next full frame 8'h5A is received correctly.
- Mode 3 (CPOL=1, CPHA=1):
  - Stimulus: tx 8'h81 and rx 8'h7E.
  - Required: both bytes are exact; poci changes only on falling sclk edges.
- Mid-frame reset and ignored write:
  - Stimulus: reset asserted after bit 3; separately, tx_write while tx_ready=0.
  - Required: on reset, all outputs take reset values and the next frame works. The ignored write does not change the held byte.

Source files
------------

// File: rtl/spi_peripheral_if.sv
// Bus bundle for the SPI peripheral: SPI pins, receive reporting, transmit holding
// register handshake, and FSM state for observation.
//
// Transmit handshake: a byte transfers on a clock edge where tx_write=1 and
// tx_ready=1. tx_write while tx_ready=0 is dropped, and tx_data is not retained.
// tx_ready stays low until the held byte is loaded into the shifter.
// rx_valid is a one-cycle strobe with no backpressure.
interface spi_peripheral_if;
  logic       sclk;
  logic       pico;
  logic       cs;
  logic       poci;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_ready;
  logic       busy;
  logic [0:0] state_dbg;

  modport slave (
    input  sclk, pico, cs, tx_data, tx_write,
    output poci, rx_data, rx_valid, tx_ready, busy, state_dbg
  );

  modport master (
    output sclk, pico, cs, tx_data, tx_write,
    input  poci, rx_data, rx_valid, tx_ready, busy, state_dbg
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI target endpoint: oversampled sclk/pico/cs, full-duplex MSB-first 8-bit frames,
// one-byte transmit holding register, single-cycle receive strobe.
module spi_peripheral #(
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2     // must be at least 2
) (
  input logic              clock,
  input logic              reset,
  spi_peripheral_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, pico_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, pico_s;

  logic [0:0] state;
  logic [2:0] bit_count;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] tx_hold;
  logic       tx_pending;
  logic       load_due;    // 8th sample seen; the next shift edge starts a new byte
  logic       poci_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, active;
  logic sample_edge, shift_edge, cs_fall, cs_rise, byte_load, tx_accept;
  logic [7:0] load_byte, shift_src;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign pico_s = pico_sync[SYNC_STAGES-1];

  // Input synchronisers plus one delay flop for sclk and cs edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      pico_sync <= '0;
      sclk_d    <= CPOL;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      pico_sync <= {pico_sync[SYNC_STAGES-2:0], bus.pico};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Edge classification; sclk edges only count inside an active frame
  always_comb begin
    sclk_rise   = sclk_s & ~sclk_d;
    sclk_fall   = ~sclk_s & sclk_d;
    lead_edge   = CPOL ? sclk_fall : sclk_rise;
    trail_edge  = CPOL ? sclk_rise : sclk_fall;
    active      = (state == SHIFT) && !cs_s;
    sample_edge = active && (CPHA ? trail_edge : lead_edge);
    shift_edge  = active && (CPHA ? lead_edge : trail_edge);
    cs_fall     = (state == IDLE) && cs_d && !cs_s;
    cs_rise     = (state == SHIFT) && cs_s;
    byte_load   = cs_fall || (shift_edge && load_due);
    load_byte   = tx_pending ? tx_hold : 8'h00;
    shift_src   = (shift_edge && load_due) ? load_byte : tx_shift;
    tx_accept   = bus.tx_write && !tx_pending;
  end

  // Holding register: a load empties it first, so a write in a load cycle
  // with nothing pending stays pending for the following byte
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_pending <= 1'b0;
      tx_hold    <= 8'h00;
    end else if (byte_load && tx_pending) begin
      tx_pending <= 1'b0;
    end else if (tx_accept) begin
      tx_pending <= 1'b1;
      tx_hold    <= bus.tx_data;
    end
  end

  // Frame FSM with transmit/receive shifters; tx_shift holds the bits still to send
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      bit_count  <= 3'd0;
      rx_shift   <= 7'd0;
      tx_shift   <= 8'h00;
      load_due   <= 1'b0;
      poci_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (cs_fall) begin
        state     <= SHIFT;
        bit_count <= 3'd0;
        rx_shift  <= 7'd0;
        load_due  <= 1'b0;
        if (CPHA) begin
          tx_shift <= load_byte;
        end else begin
          tx_shift <= {load_byte[6:0], 1'b0};
          poci_q   <= load_byte[7];
        end
      end else if (cs_rise) begin
        state     <= IDLE;
        bit_count <= 3'd0;
        rx_shift  <= 7'd0;
        load_due  <= 1'b0;
        poci_q    <= 1'b0;
      end else begin
        if (shift_edge) begin
          poci_q   <= shift_src[7];
          tx_shift <= {shift_src[6:0], 1'b0};
          load_due <= 1'b0;
        end
        if (sample_edge) begin
          rx_shift  <= {rx_shift[5:0], pico_s};
          bit_count <= bit_count + 3'd1;
          if (bit_count == 3'd7) begin
            rx_data_q  <= {rx_shift, pico_s};
            rx_valid_q <= 1'b1;
            load_due   <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.poci      = poci_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_ready  = ~tx_pending;
  assign bus.busy      = ~cs_s;
  assign bus.state_dbg = state;

endmodule
